// File: rtl/mempool_boot_ctrl.sv
// mempool_boot_ctrl
// -----------------
// Boot sequencer for a MemPool cluster. On a start request it latches the
// boot address, then raises the per-core fetch enables one core at a time
// (StaggerCycles apart). It then watches the cores' busy flags until every
// core has been idle for IdleCycles consecutive cycles. At that point it
// reports completion and keeps the result until start_i is released.
//
// Optional feature, selected at compile time by the macro
// MEMPOOL_BOOT_TIMEOUT_EN:
//   When the macro is defined, a run that reaches TimeoutCycles counted
//   cycles before completing is aborted into a TIMEOUT state, with
//   timeout_o=1 and done_o=1. When the macro is not defined, there is no
//   TIMEOUT state and timeout_o is tied to 0.
//
// Ports:
//   clk_i            rising-edge clock
//   rst_ni           asynchronous active-low reset
//   start_i          level request to boot; only honoured in IDLE
//   boot_addr_cfg_i  boot address, captured when the start is accepted
//   boot_addr_o      registered boot address to the cluster
//   fetch_enable_o   per-core fetch enable to the cluster
//   core_busy_i      per-core busy flags from the cluster (used only in RUN)
//   done_o           run finished (completion or timeout)
//   cycle_count_o    cycles spent in ENABLE plus RUN, saturating
//   timeout_o        run aborted by timeout
//
// Every output is driven straight from a flop.

module mempool_boot_ctrl #(
  parameter int unsigned NumCores      = 4,
  parameter int unsigned StaggerCycles = 2,
  parameter int unsigned IdleCycles    = 8,
  parameter int unsigned TimeoutCycles = 100000
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [31:0]         boot_addr_cfg_i,
  output logic [31:0]         boot_addr_o,
  output logic [NumCores-1:0] fetch_enable_o,
  input  logic [NumCores-1:0] core_busy_i,
  output logic                done_o,
  output logic [31:0]         cycle_count_o,
  output logic                timeout_o
);

  // Reject out-of-range parameters at elaboration time rather than
  // silently building a broken sequencer.
  if (NumCores < 1 || NumCores > 256) begin : g_bad_num_cores
    $error("mempool_boot_ctrl: NumCores must be in 1..256");
  end
  if (StaggerCycles < 1 || StaggerCycles > 255) begin : g_bad_stagger
    $error("mempool_boot_ctrl: StaggerCycles must be in 1..255");
  end
  if (IdleCycles < 1 || IdleCycles > 65535) begin : g_bad_idle
    $error("mempool_boot_ctrl: IdleCycles must be in 1..65535");
  end
  if (TimeoutCycles < 1) begin : g_bad_timeout
    $error("mempool_boot_ctrl: TimeoutCycles must be at least 1");
  end

  localparam logic [7:0]  StaggerLast = 8'(StaggerCycles - 1);
  localparam logic [15:0] IdleTarget  = 16'(IdleCycles);
  localparam logic [NumCores-1:0] FirstCore = NumCores'(1);

`ifdef MEMPOOL_BOOT_TIMEOUT_EN
  localparam logic [31:0] TimeoutLimit = 32'(TimeoutCycles);
`endif

  typedef enum logic [2:0] {
    IDLE,
    ENABLE,
    RUN,
    DONE
`ifdef MEMPOOL_BOOT_TIMEOUT_EN
    , TIMEOUT
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         boot_addr_d;
  logic [NumCores-1:0] fetch_enable_d;
  logic                done_d;
  logic [31:0]         cycle_count_d;
  logic [15:0]         idle_cnt_q, idle_cnt_d;
  logic [7:0]          stagger_cnt_q, stagger_cnt_d;

  logic [31:0]         cycle_count_inc;
  logic [15:0]         idle_cnt_inc;
  logic                all_idle;

`ifdef MEMPOOL_BOOT_TIMEOUT_EN
  logic timeout_d;
`endif

  // Helper values. The run counter saturates instead of wrapping, so a
  // very long run never looks shorter than it really was.
  assign cycle_count_inc = (cycle_count_o == 32'hFFFF_FFFF) ? cycle_count_o
                                                            : cycle_count_o + 32'd1;
  assign idle_cnt_inc    = idle_cnt_q + 16'd1;
  assign all_idle        = ~|core_busy_i;

  // Next-state and next-output logic. Each register defaults to holding
  // its value, and each state overrides only what it changes. The outputs
  // themselves are the registers, so no input reaches an output
  // combinationally.
  always_comb begin
    state_d        = state_q;
    boot_addr_d    = boot_addr_o;
    fetch_enable_d = fetch_enable_o;
    done_d         = done_o;
    cycle_count_d  = cycle_count_o;
    idle_cnt_d     = idle_cnt_q;
    stagger_cnt_d  = stagger_cnt_q;
`ifdef MEMPOOL_BOOT_TIMEOUT_EN
    timeout_d      = timeout_o;
`endif

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d        = ENABLE;
          boot_addr_d    = boot_addr_cfg_i;
          cycle_count_d  = 32'd0;
          idle_cnt_d     = 16'd0;
          stagger_cnt_d  = 8'd0;
          // Core 0 is already enabled in the first ENABLE cycle.
          fetch_enable_d = FirstCore;
          done_d         = 1'b0;
        end
      end

      ENABLE: begin
        cycle_count_d = cycle_count_inc;
        // Leave ENABLE one cycle after the last core has been switched on.
        if (fetch_enable_o[NumCores-1]) begin
          state_d = RUN;
        end else if (stagger_cnt_q == StaggerLast) begin
          stagger_cnt_d  = 8'd0;
          fetch_enable_d = (fetch_enable_o << 1) | FirstCore;
        end else begin
          stagger_cnt_d = stagger_cnt_q + 8'd1;
        end
      end

      RUN: begin
        cycle_count_d = cycle_count_inc;
        if (all_idle) begin
          idle_cnt_d = idle_cnt_inc;
          if (idle_cnt_inc == IdleTarget) begin
            state_d        = DONE;
            fetch_enable_d = '0;
            done_d         = 1'b1;
          end
        end else begin
          idle_cnt_d = 16'd0;
        end
`ifdef MEMPOOL_BOOT_TIMEOUT_EN
        // If completion happens in the same cycle, completion wins.
        if (state_d != DONE && cycle_count_inc >= TimeoutLimit) begin
          state_d        = TIMEOUT;
          fetch_enable_d = '0;
          done_d         = 1'b1;
          timeout_d      = 1'b1;
        end
`endif
      end

      DONE: begin
        // Hold the result until the requester drops start_i.
        if (!start_i) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end

`ifdef MEMPOOL_BOOT_TIMEOUT_EN
      TIMEOUT: begin
        if (!start_i) begin
          state_d   = IDLE;
          done_d    = 1'b0;
          timeout_d = 1'b0;
        end
      end
`endif

      default: begin
        state_d        = IDLE;
        fetch_enable_d = '0;
        done_d         = 1'b0;
      end
    endcase
  end

  // State and output registers. The reset is asynchronous, so a reset in
  // the middle of a run drops the fetch enables at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      boot_addr_o    <= 32'd0;
      fetch_enable_o <= '0;
      done_o         <= 1'b0;
      cycle_count_o  <= 32'd0;
      idle_cnt_q     <= 16'd0;
      stagger_cnt_q  <= 8'd0;
    end else begin
      state_q        <= state_d;
      boot_addr_o    <= boot_addr_d;
      fetch_enable_o <= fetch_enable_d;
      done_o         <= done_d;
      cycle_count_o  <= cycle_count_d;
      idle_cnt_q     <= idle_cnt_d;
      stagger_cnt_q  <= stagger_cnt_d;
    end
  end

`ifdef MEMPOOL_BOOT_TIMEOUT_EN
  // Timeout flag register. It is set on entry to TIMEOUT and cleared on the
  // way back to IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= timeout_d;
    end
  end
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_mempool_boot_ctrl.sv
// tb_mempool_boot_ctrl
// --------------------
// Directed bench for mempool_boot_ctrl with NumCores=4, StaggerCycles=2,
// IdleCycles=8 and TimeoutCycles=50. It covers the staggered enable, the
// idle-completion rule with and without an interrupted idle stretch, the
// done/start handshake, an asynchronous reset in RUN, and the timeout
// behaviour for the build in use (macro MEMPOOL_BOOT_TIMEOUT_EN).

module tb_mempool_boot_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [31:0] boot_addr_cfg_i;
  logic [31:0] boot_addr_o;
  logic [3:0]  fetch_enable_o;
  logic [3:0]  core_busy_i;
  logic        done_o;
  logic [31:0] cycle_count_o;
  logic        timeout_o;

  int checks = 0;
  int errors = 0;

  mempool_boot_ctrl #(
    .NumCores      (4),
    .StaggerCycles (2),
    .IdleCycles    (8),
    .TimeoutCycles (50)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .start_i         (start_i),
    .boot_addr_cfg_i (boot_addr_cfg_i),
    .boot_addr_o     (boot_addr_o),
    .fetch_enable_o  (fetch_enable_o),
    .core_busy_i     (core_busy_i),
    .done_o          (done_o),
    .cycle_count_o   (cycle_count_o),
    .timeout_o       (timeout_o)
  );

  // 10 ns clock period.
  always #5 clk_i = ~clk_i;

  // Compare one observed value with its expected value, and report it if
  // they differ.
  task automatic check_output(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one. Outputs are
  // then sampled, and new inputs are driven, away from the clock edge.
  task automatic apply_stimulus(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  logic [3:0] fe_exp [0:6];

  initial begin
    fe_exp[0] = 4'b0001; fe_exp[1] = 4'b0001; fe_exp[2] = 4'b0011;
    fe_exp[3] = 4'b0011; fe_exp[4] = 4'b0111; fe_exp[5] = 4'b0111;
    fe_exp[6] = 4'b1111;

    rst_ni          = 1'b0;
    start_i         = 1'b0;
    boot_addr_cfg_i = 32'h0;
    core_busy_i     = 4'b1111;
    #1;

    // Reset values.
    check_output("rst_boot_addr", boot_addr_o, 32'h0);
    check_output("rst_fetch_en", 32'(fetch_enable_o), 32'h0);
    check_output("rst_done", 32'(done_o), 32'h0);
    check_output("rst_count", cycle_count_o, 32'h0);
    check_output("rst_timeout", 32'(timeout_o), 32'h0);
    apply_stimulus(2);
    rst_ni = 1'b1;
    apply_stimulus(2);
    check_output("idle_wait_fe", 32'(fetch_enable_o), 32'h0);

    // Run 1: staggered enable, 20 busy cycles, then 8 idle cycles.
    boot_addr_cfg_i = 32'h8000_0000;
    start_i         = 1'b1;
    apply_stimulus(1);
    start_i = 1'b0;
    check_output("r1_boot_addr", boot_addr_o, 32'h8000_0000);
    for (int c = 0; c < 7; c++) begin
      if (c > 0) apply_stimulus(1);
      check_output($sformatf("r1_fe_c%0d", c), 32'(fetch_enable_o), 32'(fe_exp[c]));
    end
    check_output("r1_count_en6", cycle_count_o, 32'd6);
    apply_stimulus(1);
    check_output("r1_count_run0", cycle_count_o, 32'd7);
    check_output("r1_fe_run", 32'(fetch_enable_o), 32'hF);
    apply_stimulus(20);
    core_busy_i = 4'b0000;
    apply_stimulus(7);
    check_output("r1_done_early", 32'(done_o), 32'h0);
    apply_stimulus(1);
    check_output("r1_done", 32'(done_o), 32'h1);
    check_output("r1_fe_done", 32'(fetch_enable_o), 32'h0);
    check_output("r1_count_done", cycle_count_o, 32'd35);
    check_output("r1_timeout", 32'(timeout_o), 32'h0);
    check_output("r1_addr_held", boot_addr_o, 32'h8000_0000);
    apply_stimulus(1);
    check_output("r1_done_fall", 32'(done_o), 32'h0);
    check_output("r1_count_hold", cycle_count_o, 32'd35);

    // Run 2: a single busy cycle restarts the idle count. start_i is held
    // high throughout, so the block must stay in DONE until it drops.
    boot_addr_cfg_i = 32'h0000_1000;
    start_i         = 1'b1;
    apply_stimulus(1);
    check_output("r2_boot_addr", boot_addr_o, 32'h0000_1000);
    check_output("r2_count_clr", cycle_count_o, 32'd0);
    apply_stimulus(7);
    apply_stimulus(5);
    core_busy_i = 4'b0100;
    apply_stimulus(1);
    core_busy_i = 4'b0000;
    apply_stimulus(7);
    check_output("r2_done_early", 32'(done_o), 32'h0);
    apply_stimulus(1);
    check_output("r2_done", 32'(done_o), 32'h1);
    check_output("r2_count_done", cycle_count_o, 32'd21);
    apply_stimulus(2);
    check_output("r2_done_hold", 32'(done_o), 32'h1);
    start_i = 1'b0;
    apply_stimulus(1);
    check_output("r2_done_fall", 32'(done_o), 32'h0);

    // Run 3: asynchronous reset in the middle of RUN, then a reboot.
    core_busy_i     = 4'b1111;
    boot_addr_cfg_i = 32'hCAFE_0000;
    start_i         = 1'b1;
    apply_stimulus(1);
    start_i = 1'b0;
    apply_stimulus(10);
    check_output("r3_count_run", cycle_count_o, 32'd10);
    #2;
    rst_ni = 1'b0;
    #1;
    check_output("r3_rst_addr", boot_addr_o, 32'h0);
    check_output("r3_rst_fe", 32'(fetch_enable_o), 32'h0);
    check_output("r3_rst_done", 32'(done_o), 32'h0);
    check_output("r3_rst_count", cycle_count_o, 32'h0);
    check_output("r3_rst_timeout", 32'(timeout_o), 32'h0);
    #2;
    rst_ni = 1'b1;
    apply_stimulus(3);
    check_output("r3_wait_fe", 32'(fetch_enable_o), 32'h0);
    check_output("r3_wait_count", cycle_count_o, 32'h0);
    boot_addr_cfg_i = 32'h1234_5678;
    start_i         = 1'b1;
    apply_stimulus(1);
    start_i = 1'b0;
    check_output("r3_reboot_addr", boot_addr_o, 32'h1234_5678);
    check_output("r3_reboot_fe", 32'(fetch_enable_o), 32'h1);
    check_output("r3_reboot_count0", cycle_count_o, 32'd0);
    apply_stimulus(1);
    check_output("r3_reboot_count1", cycle_count_o, 32'd1);

    // Run 3 continued: cores never go idle, and the counter approaches 50.
    apply_stimulus(48);
    check_output("r4_count49", cycle_count_o, 32'd49);
    check_output("r4_done49", 32'(done_o), 32'h0);
    check_output("r4_timeout49", 32'(timeout_o), 32'h0);
    apply_stimulus(1);
    check_output("r4_count50", cycle_count_o, 32'd50);
`ifdef MEMPOOL_BOOT_TIMEOUT_EN
    check_output("r4_timeout", 32'(timeout_o), 32'h1);
    check_output("r4_done", 32'(done_o), 32'h1);
    check_output("r4_fe", 32'(fetch_enable_o), 32'h0);
    apply_stimulus(5);
    check_output("r4_count_hold", cycle_count_o, 32'd50);
`else
    check_output("r4_timeout", 32'(timeout_o), 32'h0);
    check_output("r4_done", 32'(done_o), 32'h0);
    check_output("r4_fe", 32'(fetch_enable_o), 32'hF);
    apply_stimulus(10);
    check_output("r4_done_later", 32'(done_o), 32'h0);
    check_output("r4_count60", cycle_count_o, 32'd60);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
